// File: rtl/hdmi_tmds_pkg.sv
// +----------------------------------------------------------------------------+
// | hdmi_tmds_pkg : TMDS widths, control tokens and popcount helper            |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package hdmi_tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;

  localparam logic [SYM_W-1:0] c_token_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] c_token_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] c_token_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] c_token_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_channel.sv
// +----------------------------------------------------------------------------+
// | tmds_channel : one TMDS 8b/10b lane, transition-minimise then DC-balance   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tmds_channel
  import hdmi_tmds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  input  logic              c1,
  input  logic              c0,
  input  logic              de,
  output logic [SYM_W-1:0]  sym
);

  logic [3:0]               w_n1d;
  logic                     w_use_xnor;
  logic [DATA_W:0]          w_q_m;

  logic [DATA_W:0]          r_q_m;
  logic                     r_de;
  logic [1:0]               r_c;

  logic [3:0]               w_n1;
  logic [3:0]               w_n0;
  logic signed [CNT_W-1:0]  w_diff;
  logic signed [CNT_W-1:0]  w_two_q8;
  logic signed [CNT_W-1:0]  w_two_nq8;
  logic signed [CNT_W-1:0]  w_cnt_nxt;
  logic [SYM_W-1:0]         w_sym_nxt;

  logic signed [CNT_W-1:0]  r_cnt;
  logic [SYM_W-1:0]         r_sym;

  always_comb begin
    w_n1d      = popcount8(d);
    w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
    w_q_m      = '0;
    w_q_m[0]   = d[0];
    for (int i = 1; i < DATA_W; i++) begin
      w_q_m[i] = w_use_xnor ? ~(w_q_m[i-1] ^ d[i]) : (w_q_m[i-1] ^ d[i]);
    end
    w_q_m[DATA_W] = ~w_use_xnor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_m <= '0;
      r_de  <= 1'b0;
      r_c   <= 2'b00;
    end else begin
      r_q_m <= w_q_m;
      r_de  <= de;
      r_c   <= {c1, c0};
    end
  end

  // Popcounts are at most 8, so the zero-extended 5-bit difference cannot overflow.
  always_comb begin
    w_n1      = popcount8(r_q_m[DATA_W-1:0]);
    w_n0      = 4'd8 - w_n1;
    w_diff    = $signed({1'b0, w_n1}) - $signed({1'b0, w_n0});
    w_two_q8  = {3'b000, r_q_m[DATA_W], 1'b0};
    w_two_nq8 = {3'b000, ~r_q_m[DATA_W], 1'b0};
    w_sym_nxt = c_token_00;
    w_cnt_nxt = '0;
    if (!r_de) begin
      case (r_c)
        2'b00:   w_sym_nxt = c_token_00;
        2'b01:   w_sym_nxt = c_token_01;
        2'b10:   w_sym_nxt = c_token_10;
        default: w_sym_nxt = c_token_11;
      endcase
      w_cnt_nxt = '0;
    end else if ((r_cnt == 0) || (w_n1 == w_n0)) begin
      w_sym_nxt = {~r_q_m[DATA_W], r_q_m[DATA_W],
                   r_q_m[DATA_W] ? r_q_m[DATA_W-1:0] : ~r_q_m[DATA_W-1:0]};
      w_cnt_nxt = r_q_m[DATA_W] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if (((r_cnt > 0) && (w_n1 > w_n0)) || ((r_cnt < 0) && (w_n0 > w_n1))) begin
      w_sym_nxt = {1'b1, r_q_m[DATA_W], ~r_q_m[DATA_W-1:0]};
      w_cnt_nxt = r_cnt + w_two_q8 - w_diff;
    end else begin
      w_sym_nxt = {1'b0, r_q_m[DATA_W], r_q_m[DATA_W-1:0]};
      w_cnt_nxt = r_cnt - w_two_nq8 + w_diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym <= c_token_00;
      r_cnt <= '0;
    end else begin
      r_sym <= w_sym_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign sym = r_sym;

endmodule

`default_nettype wire

// File: rtl/tmds_encoder.sv
// +----------------------------------------------------------------------------+
// | tmds_encoder : three-lane TMDS encoder, syncs carried on blue (channel 0)  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tmds_encoder
  import hdmi_tmds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] red_i,
  input  logic [DATA_W-1:0] green_i,
  input  logic [DATA_W-1:0] blue_i,
  input  logic              hSync_i,
  input  logic              vSync_i,
  input  logic              drawArea_i,
  output logic [SYM_W-1:0]  tmds_b_o,
  output logic [SYM_W-1:0]  tmds_g_o,
  output logic [SYM_W-1:0]  tmds_r_o
);

  tmds_channel u_ch0_blue (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (blue_i),
    .c1    (vSync_i),
    .c0    (hSync_i),
    .de    (drawArea_i),
    .sym   (tmds_b_o)
  );

  // No data islands, so the green and red lanes only ever send the 00 token.
  tmds_channel u_ch1_green (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (green_i),
    .c1    (1'b0),
    .c0    (1'b0),
    .de    (drawArea_i),
    .sym   (tmds_g_o)
  );

  tmds_channel u_ch2_red (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (red_i),
    .c1    (1'b0),
    .c0    (1'b0),
    .de    (drawArea_i),
    .sym   (tmds_r_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_tmds_encoder.sv
// +----------------------------------------------------------------------------+
// | tb_tmds_encoder : directed and scoreboarded random checks of tmds_encoder  |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tmds_encoder;

  localparam logic [9:0] c_tok00 = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] red, green, blue;
  logic       hs, vs, de;
  logic [9:0] tmds_b, tmds_g, tmds_r;

  int n_vec = 0;
  int n_err = 0;

  int         cnt_m [3];
  logic [29:0] sb_q [$];

  always #5 clk = ~clk;

  tmds_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .red_i      (red),
    .green_i    (green),
    .blue_i     (blue),
    .hSync_i    (hs),
    .vSync_i    (vs),
    .drawArea_i (de),
    .tmds_b_o   (tmds_b),
    .tmds_g_o   (tmds_g),
    .tmds_r_o   (tmds_r)
  );

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] ref_enc(input int ch, input logic [7:0] d,
                                         input logic [1:0] c, input logic en);
    logic [8:0] qm;
    int ones, n1, n0;
    bit xn;
    logic [9:0] s;
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = xn ? 1'b0 : 1'b1;
    if (!en) begin
      cnt_m[ch] = 0;
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      return s;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt_m[ch] == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_m[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((cnt_m[ch] > 0 && n1 > n0) || (cnt_m[ch] < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt_m[ch] += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt_m[ch] += (qm[8] ? 0 : -2) + n1 - n0;
    end
    return s;
  endfunction

  // Pipeline contents are lost on reset; the first post-reset symbol is the 00 token.
  always @(negedge rst_n) begin
    sb_q.delete();
    for (int i = 0; i < 3; i++) cnt_m[i] = 0;
    sb_q.push_back({c_tok00, c_tok00, c_tok00});
  end

  always @(posedge clk) begin
    logic [29:0] e;
    if (rst_n === 1'b1) begin
      sb_q.push_back({ref_enc(2, red, 2'b00, de), ref_enc(1, green, 2'b00, de),
                      ref_enc(0, blue, {vs, hs}, de)});
      #1;
      if (sb_q.size() > 1) begin
        e = sb_q.pop_front();
        check_eq("sb_red",   tmds_r, e[29:20]);
        check_eq("sb_green", tmds_g, e[19:10]);
        check_eq("sb_blue",  tmds_b, e[9:0]);
      end
    end
  end

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic h, input logic v, input logic en);
    @(negedge clk);
    red = r; green = g; blue = b; hs = h; vs = v; de = en;
  endtask

  initial begin
    rst_n = 1'b1;
    red = 8'h00; green = 8'h00; blue = 8'h00; hs = 1'b0; vs = 1'b0; de = 1'b0;
    #1 rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
    end
    check_eq("rst_b", tmds_b, c_tok00);
    check_eq("rst_g", tmds_g, c_tok00);
    check_eq("rst_r", tmds_r, c_tok00);

    @(negedge clk);
    hs = 1'b0; vs = 1'b0; de = 1'b0; rst_n = 1'b1;
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_b", tmds_b, c_tok00);
    check_eq("post_rst_r", tmds_r, c_tok00);

    // hSync only
    repeat (3) pix(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("ctl_hs_b", tmds_b, 10'b0010101011);
    check_eq("ctl_hs_g", tmds_g, c_tok00);
    check_eq("ctl_hs_r", tmds_r, c_tok00);
    repeat (3) pix(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    check_eq("ctl_hv_b", tmds_b, 10'b1010101011);

    // 0x00 run from zero disparity
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("z0_b", tmds_b, 10'b0100000000);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("z1_g", tmds_g, 10'b1111111111);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("z2_r", tmds_r, 10'b0100000000);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("z3_b", tmds_b, 10'b1111111111);

    // one-pixel blanking clears disparity
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("blank_tok_g", tmds_g, c_tok00);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_clr_b", tmds_b, 10'b0100000000);

    // 0xFF from zero disparity
    pix(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("ff_b", tmds_b, 10'b1000000000);
    check_eq("ff_r", tmds_r, 10'b1000000000);

    // asynchronous reset in the middle of a line
    repeat (5) pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_b", tmds_b, c_tok00);
    check_eq("arst_g", tmds_g, c_tok00);
    check_eq("arst_r", tmds_r, c_tok00);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("arst_cnt0_b", tmds_b, 10'b0100000000);

    repeat (10000) begin
      pix(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
    end
    repeat (4) pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
